// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between eight requesters and rr_arbiter_8.
// The master side drives requests and done; the slave (arbiter) drives the grant.
interface rr_arbiter_8_if;
  logic [7:0] i_req;
  logic       i_done;
  logic       o_en;
  logic [2:0] o_idx;
  logic       o_timeout;

  modport master (
    output i_req,
    output i_done,
    input  o_en,
    input  o_idx,
    input  o_timeout
  );

  modport slave (
    input  i_req,
    input  i_done,
    output o_en,
    output o_idx,
    output o_timeout
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a bounded hold time and a one-cycle
// break-before-make bubble; drives a downstream 3-to-8 one-hot decoder.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  rr_arbiter_8_if.slave  bus
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          en_q, en_d;
  logic [2:0]    idx_q, idx_d;
  logic          to_q, to_d;

  logic          win_found;
  logic [2:0]    win_idx;
  logic [2:0]    cand;
  logic          rel_done, rel_drop, rel_expire;

  // Rotating priority search: ptr has highest priority, wrapping 7 -> 0.
  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!win_found && bus.i_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign rel_done   = bus.i_done;
  assign rel_drop   = !bus.i_req[idx_q];
  assign rel_expire = (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    en_d    = en_q;
    idx_d   = idx_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (win_found) begin
          idx_d   = win_idx;
          en_d    = 1'b1;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_expire) begin
          ptr_d   = idx_q + 3'd1;
          en_d    = 1'b0;
          state_d = IDLE;
          // Simultaneous done or drop takes precedence over the hold limit.
          to_d    = rel_expire && !rel_done && !rel_drop;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      en_q    <= 1'b0;
      idx_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      en_q    <= en_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
    end
  end

  assign bus.o_en      = en_q;
  assign bus.o_idx     = idx_q;
  assign bus.o_timeout = to_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: one instance with MAX_HOLD=16 and one
// with MAX_HOLD=4, sharing clock and reset.
module tb_rr_arbiter_8;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rr_arbiter_8_if if16 ();
  rr_arbiter_8_if if4 ();

  rr_arbiter_8 #(.MAX_HOLD(16)) dut16 (.i_clk(i_clk), .i_rst(i_rst), .bus(if16.slave));
  rr_arbiter_8 #(.MAX_HOLD(4))  dut4  (.i_clk(i_clk), .i_rst(i_rst), .bus(if4.slave));

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    if16.i_req = '0; if16.i_done = 1'b0;
    if4.i_req  = '0; if4.i_done  = 1'b0;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    if16.i_req = 8'h20;
    tick();
    checks++;
    if (if16.o_en !== 1'b1 || if16.o_idx !== 3'd5) begin
      errors++;
      $display("FAIL reset_pre_grant en=%b idx=%0d want en=1 idx=5", if16.o_en, if16.o_idx);
    end
    tick();
    #2 i_rst = 1'b1;
    #1;
    checks++;
    if (if16.o_en !== 1'b0 || if16.o_idx !== 3'd0 || if16.o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_async en=%b idx=%0d to=%b want 0 0 0", if16.o_en, if16.o_idx, if16.o_timeout);
    end
    tick();
    checks++;
    if (if16.o_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_held en=%b want 0", if16.o_en);
    end
    i_rst = 1'b0;
    if16.i_req = 8'hFF;
    tick();
    checks++;
    if (if16.o_en !== 1'b1 || if16.o_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_resume en=%b idx=%0d want en=1 idx=0", if16.o_en, if16.o_idx);
    end
  endtask

  task automatic test_single();
    apply_reset();
    if16.i_req = 8'b0000_0100;
    tick();
    checks++;
    if (if16.o_en !== 1'b1 || if16.o_idx !== 3'd2) begin
      errors++;
      $display("FAIL single_grant en=%b idx=%0d want en=1 idx=2", if16.o_en, if16.o_idx);
    end
    tick();
    tick();
    checks++;
    if (if16.o_en !== 1'b1) begin
      errors++;
      $display("FAIL single_cycle3 en=%b want 1", if16.o_en);
    end
    if16.i_done = 1'b1;
    tick();
    if16.i_done = 1'b0;
    checks++;
    if (if16.o_en !== 1'b0 || if16.o_idx !== 3'd2 || if16.o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL single_bubble en=%b idx=%0d to=%b want 0 2 0", if16.o_en, if16.o_idx, if16.o_timeout);
    end
    tick();
    checks++;
    if (if16.o_en !== 1'b1 || if16.o_idx !== 3'd2) begin
      errors++;
      $display("FAIL single_regrant en=%b idx=%0d want en=1 idx=2", if16.o_en, if16.o_idx);
    end
  endtask

  // i_done stays high through the bubbles too, since IDLE ignores it.
  task automatic test_fairness();
    apply_reset();
    if16.i_req  = 8'hFF;
    if16.i_done = 1'b1;
    for (int g = 0; g < 9; g++) begin
      tick();
      checks++;
      if (if16.o_en !== 1'b1 || if16.o_idx !== 3'(g % 8)) begin
        errors++;
        $display("FAIL fair_grant%0d en=%b idx=%0d want en=1 idx=%0d", g, if16.o_en, if16.o_idx, g % 8);
      end
      tick();
      checks++;
      if (if16.o_en !== 1'b0 || if16.o_idx !== 3'(g % 8)) begin
        errors++;
        $display("FAIL fair_bubble%0d en=%b idx=%0d want en=0 idx=%0d", g, if16.o_en, if16.o_idx, g % 8);
      end
    end
    if16.i_done = 1'b0;
  endtask

  task automatic test_wrap();
    apply_reset();
    if16.i_req = 8'h20;
    tick();
    if16.i_done = 1'b1;
    tick();
    if16.i_done = 1'b0;
    if16.i_req  = 8'b0000_0011;
    tick();
    checks++;
    if (if16.o_en !== 1'b1 || if16.o_idx !== 3'd0) begin
      errors++;
      $display("FAIL wrap_first en=%b idx=%0d want en=1 idx=0", if16.o_en, if16.o_idx);
    end
    if16.i_done = 1'b1;
    tick();
    if16.i_done = 1'b0;
    tick();
    checks++;
    if (if16.o_en !== 1'b1 || if16.o_idx !== 3'd1) begin
      errors++;
      $display("FAIL wrap_second en=%b idx=%0d want en=1 idx=1", if16.o_en, if16.o_idx);
    end
  endtask

  task automatic test_timeout();
    int len;
    int bad;
    apply_reset();
    if16.i_req = 8'h09;
    tick();
    len = 0;
    bad = 0;
    while (if16.o_en === 1'b1 && len < 40) begin
      if (if16.o_idx !== 3'd0 || if16.o_timeout !== 1'b0) bad++;
      len++;
      tick();
    end
    checks++;
    if (len != 16 || bad != 0) begin
      errors++;
      $display("FAIL timeout_len cycles=%0d glitches=%0d want cycles=16 glitches=0", len, bad);
    end
    checks++;
    if (if16.o_en !== 1'b0 || if16.o_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse en=%b to=%b want en=0 to=1", if16.o_en, if16.o_timeout);
    end
    tick();
    checks++;
    if (if16.o_en !== 1'b1 || if16.o_idx !== 3'd3 || if16.o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_next en=%b idx=%0d to=%b want 1 3 0", if16.o_en, if16.o_idx, if16.o_timeout);
    end
  endtask

  task automatic test_drop_vs_timeout();
    int len;
    // Plain timeout on the short-hold instance.
    apply_reset();
    if4.i_req = 8'h02;
    tick();
    len = 0;
    while (if4.o_en === 1'b1 && len < 20) begin
      len++;
      tick();
    end
    checks++;
    if (len != 4 || if4.o_timeout !== 1'b1) begin
      errors++;
      $display("FAIL hold4_timeout cycles=%0d to=%b want cycles=4 to=1", len, if4.o_timeout);
    end
    // Drop in the 4th grant cycle.
    apply_reset();
    if4.i_req = 8'h02;
    tick();
    tick();
    tick();
    tick();
    if4.i_req = 8'h00;
    tick();
    checks++;
    if (if4.o_en !== 1'b0 || if4.o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL drop_at_limit en=%b to=%b want en=0 to=0", if4.o_en, if4.o_timeout);
    end
    // Done in the 4th grant cycle.
    if4.i_req = 8'h02;
    tick();
    checks++;
    if (if4.o_en !== 1'b1 || if4.o_idx !== 3'd1) begin
      errors++;
      $display("FAIL done_grant en=%b idx=%0d want en=1 idx=1", if4.o_en, if4.o_idx);
    end
    tick();
    tick();
    tick();
    if4.i_done = 1'b1;
    tick();
    if4.i_done = 1'b0;
    checks++;
    if (if4.o_en !== 1'b0 || if4.o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL done_at_limit en=%b to=%b want en=0 to=0", if4.o_en, if4.o_timeout);
    end
  endtask

  initial begin
    if16.i_req = '0; if16.i_done = 1'b0;
    if4.i_req  = '0; if4.i_done  = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_timeout();
    test_drop_vs_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
